// File: rtl/counter_pkg.sv
// counter_pkg: default width/step constants and the count type for the free-running counter
package counter_pkg;
    localparam int unsigned COUNTER_WIDTH = 32;
    localparam int unsigned COUNTER_STEP = 1;
    typedef logic [COUNTER_WIDTH-1:0] count_t;
endpackage

// File: rtl/counter_slice.sv
// counter_slice: W-bit adder slice with carry-in and carry-out
module counter_slice
    import counter_pkg::*;
#(
    parameter int unsigned W = COUNTER_WIDTH / 2
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o
);
    assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
endmodule

// File: rtl/counter_32_bit.sv
// counter_32_bit: free-running modulo-2**WIDTH up-counter with registered wrap pulse
module counter_32_bit
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH       = COUNTER_WIDTH,
    parameter logic [WIDTH-1:0] STEP        = WIDTH'(COUNTER_STEP),
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max
);
    localparam int unsigned H = WIDTH / 2;

    if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
        $error("counter_32_bit: WIDTH must be even and at least 2");
    end
    if (STEP == '0) begin : g_bad_step
        $error("counter_32_bit: STEP must be non-zero");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d, c_mid;

    // Two half-width slices chained in the same cycle; the high carry-out is the wrap.
    counter_slice #(.W(H)) u_lo (
        .a_i  (count_q[H-1:0]),
        .b_i  (STEP[H-1:0]),
        .c_i  (1'b0),
        .sum_o(count_d[H-1:0]),
        .c_o  (c_mid)
    );

    counter_slice #(.W(H)) u_hi (
        .a_i  (count_q[WIDTH-1:H]),
        .b_i  (STEP[WIDTH-1:H]),
        .c_i  (c_mid),
        .sum_o(count_d[WIDTH-1:H]),
        .c_o  (wrap_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign at_max = &count_q;
endmodule

// File: tb/tb_counter_32_bit.sv
// tb_counter_32_bit: scoreboard bench over four counter configurations sharing one clock
module tb_counter_32_bit;
    import counter_pkg::*;

    typedef struct {
        count_t c;
        logic   w;
        logic   m;
    } exp_t;

    logic   clk = 1'b0;
    logic   [3:0] rst_v = 4'hF;
    count_t ac [4];
    logic   aw [4];
    logic   am [4];

    count_t rv [4] = '{32'h0000_0000, 32'hFFFF_FFFD, 32'h0000_FFFF, 32'hFFFF_FFFE};
    count_t st [4] = '{32'd1, 32'd1, 32'd1, 32'd3};
    count_t mc [4];
    logic   mw [4];
    exp_t   q [$];
    int     n_vec = 0;
    int     n_bad = 0;

    always #5 clk = ~clk;

    counter_32_bit u0 (.clk(clk), .reset(rst_v[0]), .count(ac[0]), .wrap(aw[0]), .at_max(am[0]));
    counter_32_bit #(.RESET_VALUE(32'hFFFF_FFFD)) u1 (
        .clk(clk), .reset(rst_v[1]), .count(ac[1]), .wrap(aw[1]), .at_max(am[1]));
    counter_32_bit #(.RESET_VALUE(32'h0000_FFFF)) u2 (
        .clk(clk), .reset(rst_v[2]), .count(ac[2]), .wrap(aw[2]), .at_max(am[2]));
    counter_32_bit #(.STEP(32'd3), .RESET_VALUE(32'hFFFF_FFFE)) u3 (
        .clk(clk), .reset(rst_v[3]), .count(ac[3]), .wrap(aw[3]), .at_max(am[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one reset pattern, predict every counter, then compare just after the edge.
    task automatic step(input logic [3:0] r);
        exp_t e;
        logic [32:0] s;
        rst_v = r;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) begin
                mc[i] = rv[i];
                mw[i] = 1'b0;
            end else begin
                s = {1'b0, mc[i]} + {1'b0, st[i]};
                mc[i] = s[31:0];
                mw[i] = s[32];
            end
            e.c = mc[i];
            e.w = mw[i];
            e.m = (mc[i] == 32'hFFFF_FFFF);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            e = q.pop_front();
            chk($sformatf("d%0d_count", i), ac[i], e.c);
            chk($sformatf("d%0d_wrap", i), 32'(aw[i]), 32'(e.w));
            chk($sformatf("d%0d_at_max", i), 32'(am[i]), 32'(e.m));
        end
    endtask

    initial begin
        step(4'hF);
        chk("rst_count", ac[0], 32'h0);
        chk("rst_wrap", 32'(aw[0]), 32'h0);
        chk("rst_at_max", 32'(am[0]), 32'h0);
        step(4'h0);
        chk("first_inc", ac[0], 32'h1);
        chk("slice_carry", ac[2], 32'h0001_0000);
        chk("slice_carry_wrap", 32'(aw[2]), 32'h0);
        chk("step3_count", ac[3], 32'h0000_0001);
        chk("step3_wrap", 32'(aw[3]), 32'h1);
        step(4'h0);
        chk("roll_max", ac[1], 32'hFFFF_FFFF);
        chk("roll_at_max", 32'(am[1]), 32'h1);
        step(4'h0);
        chk("roll_zero", ac[1], 32'h0);
        chk("roll_wrap", 32'(aw[1]), 32'h1);
        step(4'h0);
        chk("roll_one", ac[1], 32'h1);
        chk("roll_wrap_clr", 32'(aw[1]), 32'h0);
        for (int k = 0; k < 6; k++) step(4'h0);
        chk("count_ten", ac[0], 32'hA);
        step(4'b0001);
        for (int k = 0; k < 7; k++) step(4'h0);
        chk("pre_mid_rst", ac[0], 32'h7);
        step(4'b0001);
        chk("mid_rst", ac[0], 32'h0);
        step(4'h0);
        chk("mid_rst_release", ac[0], 32'h1);
        step(4'b0010);
        step(4'h0);
        step(4'h0);
        chk("coll_pre", ac[1], 32'hFFFF_FFFF);
        step(4'b0010);
        chk("coll_count", ac[1], 32'hFFFF_FFFD);
        chk("coll_wrap", 32'(aw[1]), 32'h0);
        for (int k = 0; k < 40; k++) step(4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
